// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rename aliases, captures CDB results,
// answers operand queries with CDB bypass, and retires/flushes from the head.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int ID_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,

    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,
    input  logic              alloc_is_br,
    input  logic              alloc_pred_taken,
    input  logic [DATA_W-1:0] alloc_alt_pc,
    output logic [ID_W-1:0]   alloc_id,
    output logic              rob_full,

    input  logic              cdb_valid,
    input  logic [ID_W-1:0]   cdb_id,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_taken,

    input  logic [ID_W-1:0]   qry_id1,
    input  logic [ID_W-1:0]   qry_id2,
    output logic              qry_rdy1,
    output logic              qry_rdy2,
    output logic [DATA_W-1:0] qry_val1,
    output logic [DATA_W-1:0] qry_val2,

    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic [ID_W-1:0]   commit_id,
    output logic [DATA_W-1:0] commit_value,

    output logic              rollback_signal,
    output logic [DATA_W-1:0] rollback_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ID_W-1:0]  DEPTH_ID  = ID_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]        rd;
        logic              is_br;
        logic              pred_taken;
        logic [DATA_W-1:0] alt_pc;
    } meta_t;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ready;

    meta_t             meta_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic              taken_q [DEPTH];

    logic [ID_W-1:0]   cdb_off;
    logic [PTR_W-1:0]  cdb_idx;
    logic              cdb_in_range;
    logic              cdb_write;
    logic              alloc_fire;
    logic              mispredict;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  tail_next;

    assign alloc_id = ID_W'(tail) + ID_W'(1);
    assign rob_full = (count == DEPTH_CNT);

    assign cdb_off      = cdb_id - ID_W'(1);
    assign cdb_idx      = cdb_off[PTR_W-1:0];
    assign cdb_in_range = (cdb_id != '0) && (cdb_id <= DEPTH_ID);
    // A broadcast naming a slot that holds no live instruction is dropped.
    assign cdb_write    = rdy && cdb_valid && !rollback_signal && cdb_in_range && busy[cdb_idx];
    assign alloc_fire   = rdy && alloc_valid && !rob_full && !rollback_signal;

    assign head_next = (head == LAST_PTR) ? '0 : head + PTR_W'(1);
    assign tail_next = (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);

    // Head readiness is registered, so a result arriving this cycle retires next cycle.
    assign commit_valid = rdy && (count != '0) && ready[head] && !rollback_signal;
    assign commit_rd    = meta_q[head].rd;
    assign commit_id    = ID_W'(head) + ID_W'(1);
    assign commit_value = value_q[head];
    assign mispredict   = commit_valid && meta_q[head].is_br &&
                          (taken_q[head] != meta_q[head].pred_taken);

    function automatic logic [DATA_W:0] lookup(input logic [ID_W-1:0] id);
        logic [ID_W-1:0]  off;
        logic [PTR_W-1:0] idx;
        off = id - ID_W'(1);
        idx = off[PTR_W-1:0];
        if (id == '0 || id > DEPTH_ID)
            return {1'b0, {DATA_W{1'b0}}};
        if (cdb_valid && cdb_id == id)
            return {1'b1, cdb_value};
        if (ready[idx])
            return {1'b1, value_q[idx]};
        return {1'b0, {DATA_W{1'b0}}};
    endfunction

    assign {qry_rdy1, qry_val1} = lookup(qry_id1);
    assign {qry_rdy2, qry_val2} = lookup(qry_id2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            busy            <= '0;
            ready           <= '0;
            rollback_signal <= 1'b0;
            rollback_pc     <= '0;
        end else if (rdy) begin
            if (mispredict) begin
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                busy            <= '0;
                ready           <= '0;
                rollback_signal <= 1'b1;
                rollback_pc     <= meta_q[head].alt_pc;
            end else begin
                rollback_signal <= 1'b0;
                if (cdb_write)
                    ready[cdb_idx] <= 1'b1;
                if (alloc_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail_next;
                end
                // Commit clears last so it wins over a same-cycle write to the head slot.
                if (commit_valid) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head_next;
                end
                case ({alloc_fire, commit_valid})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: payload storage is not reset; busy/ready gate every read of it.
    always_ff @(posedge clk) begin
        if (alloc_fire)
            meta_q[tail] <= '{rd: alloc_rd, is_br: alloc_is_br,
                              pred_taken: alloc_pred_taken, alt_pc: alloc_alt_pc};
        if (cdb_write) begin
            value_q[cdb_idx] <= cdb_value;
            taken_q[cdb_idx] <= cdb_taken;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retirements are queued at
// allocation and a negedge monitor compares every commit against them.
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int ID_W   = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic              alloc_is_br;
    logic              alloc_pred_taken;
    logic [DATA_W-1:0] alloc_alt_pc;
    logic [ID_W-1:0]   alloc_id;
    logic              rob_full;
    logic              cdb_valid;
    logic [ID_W-1:0]   cdb_id;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_taken;
    logic [ID_W-1:0]   qry_id1, qry_id2;
    logic              qry_rdy1, qry_rdy2;
    logic [DATA_W-1:0] qry_val1, qry_val2;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [ID_W-1:0]   commit_id;
    logic [DATA_W-1:0] commit_value;
    logic              rollback_signal;
    logic [DATA_W-1:0] rollback_pc;

    reorder_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br),
        .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
        .alloc_id(alloc_id), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .qry_id1(qry_id1), .qry_id2(qry_id2), .qry_rdy1(qry_rdy1), .qry_rdy2(qry_rdy2),
        .qry_val1(qry_val1), .qry_val2(qry_val2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_id(commit_id),
        .commit_value(commit_value),
        .rollback_signal(rollback_signal), .rollback_pc(rollback_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        rd;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] value;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && commit_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got id %0d expected no commit", commit_id);
            end else begin
                e = sb.pop_front();
                check("commit_rd", 32'(commit_rd), 32'(e.rd));
                check("commit_id", 32'(commit_id), 32'(e.id));
                check("commit_value", commit_value, e.value);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid      = 1'b0;
        alloc_rd         = '0;
        alloc_is_br      = 1'b0;
        alloc_pred_taken = 1'b0;
        alloc_alt_pc     = '0;
        cdb_valid        = 1'b0;
        cdb_id           = '0;
        cdb_value        = '0;
        cdb_taken        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        qry_id1 = '0;
        qry_id2 = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic is_br, input logic pred,
                         input logic [DATA_W-1:0] alt);
        alloc_valid      = 1'b1;
        alloc_rd         = rd;
        alloc_is_br      = is_br;
        alloc_pred_taken = pred;
        alloc_alt_pc     = alt;
        step();
        alloc_valid      = 1'b0;
    endtask

    task automatic cdb(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] val, input logic taken);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_value = val;
        cdb_taken = taken;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic expect_commit(input logic [4:0] rd, input logic [ID_W-1:0] id,
                                 input logic [DATA_W-1:0] val);
        sb.push_back('{rd: rd, id: id, value: val});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            step();
        check(name, 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and a single alloc/result/commit.
        do_reset();
        check("reset_alloc_id", 32'(alloc_id), 32'd1);
        check("reset_rob_full", 32'(rob_full), 32'd0);
        check("reset_commit_valid", 32'(commit_valid), 32'd0);
        check("reset_rollback", 32'(rollback_signal), 32'd0);
        check("reset_rollback_pc", rollback_pc, 32'd0);
        expect_commit(5'd5, 5'd1, 32'hDEAD);
        alloc(5'd5, 1'b0, 1'b0, '0);
        check("first_alloc_next_id", 32'(alloc_id), 32'd2);
        cdb_valid = 1'b1; cdb_id = 5'd1; cdb_value = 32'hDEAD; cdb_taken = 1'b0;
        #1 check("cdb_head_no_same_cycle_commit", 32'(commit_valid), 32'd0);
        step();
        cdb_valid = 1'b0;
        check("commit_after_cdb", 32'(commit_valid), 32'd1);
        drain("drain_single");

        // Fill, refuse overflow, refuse alloc on a full-ROB commit, wrap the tail.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            expect_commit(5'(i), 5'(i), 32'h100 + 32'(i));
            alloc(5'(i), 1'b0, 1'b0, '0);
        end
        check("full_after_16", 32'(rob_full), 32'd1);
        check("full_alloc_id_wrapped", 32'(alloc_id), 32'd1);
        alloc(5'd31, 1'b0, 1'b0, '0);
        check("overflow_full", 32'(rob_full), 32'd1);
        check("overflow_alloc_id", 32'(alloc_id), 32'd1);
        cdb(5'd1, 32'h101, 1'b0);
        check("full_head_commit", 32'(commit_valid), 32'd1);
        alloc(5'd20, 1'b0, 1'b0, '0);
        check("full_commit_alloc_refused", 32'(rob_full), 32'd0);
        check("full_commit_alloc_id", 32'(alloc_id), 32'd1);
        expect_commit(5'd20, 5'd1, 32'h120);
        alloc(5'd20, 1'b0, 1'b0, '0);
        check("wrap_alloc_full", 32'(rob_full), 32'd1);
        check("wrap_alloc_id", 32'(alloc_id), 32'd2);
        for (int i = 2; i <= DEPTH; i++)
            cdb(5'(i), 32'h100 + 32'(i), 1'b0);
        cdb(5'd1, 32'h120, 1'b0);
        drain("drain_full");

        // Out-of-order results retire in order.
        do_reset();
        expect_commit(5'd1, 5'd1, 32'h11);
        expect_commit(5'd2, 5'd2, 32'h22);
        expect_commit(5'd3, 5'd3, 32'h33);
        alloc(5'd1, 1'b0, 1'b0, '0);
        alloc(5'd2, 1'b0, 1'b0, '0);
        alloc(5'd3, 1'b0, 1'b0, '0);
        cdb(5'd3, 32'h33, 1'b0);
        check("ooo_no_commit_after_3", 32'(commit_valid), 32'd0);
        cdb(5'd2, 32'h22, 1'b0);
        check("ooo_no_commit_after_2", 32'(commit_valid), 32'd0);
        cdb(5'd1, 32'h11, 1'b0);
        check("ooo_commit_cycle1", 32'(commit_valid), 32'd1);
        step();
        check("ooo_commit_cycle2", 32'(commit_valid), 32'd1);
        step();
        check("ooo_commit_cycle3", 32'(commit_valid), 32'd1);
        step();
        check("ooo_commit_done", 32'(commit_valid), 32'd0);
        drain("drain_ooo");

        // Operand queries with and without CDB bypass.
        do_reset();
        expect_commit(5'd1, 5'd1, 32'h99);
        expect_commit(5'd2, 5'd2, 32'h7);
        alloc(5'd1, 1'b0, 1'b0, '0);
        alloc(5'd2, 1'b0, 1'b0, '0);
        qry_id1 = 5'd2; qry_id2 = 5'd1;
        cdb_valid = 1'b1; cdb_id = 5'd2; cdb_value = 32'h7;
        #1;
        check("qry_bypass_rdy", 32'(qry_rdy1), 32'd1);
        check("qry_bypass_val", qry_val1, 32'h7);
        check("qry_pending_rdy", 32'(qry_rdy2), 32'd0);
        step();
        cdb_valid = 1'b0;
        qry_id2 = 5'd2;
        qry_id1 = 5'd0;
        #1;
        check("qry_stored_rdy", 32'(qry_rdy2), 32'd1);
        check("qry_stored_val", qry_val2, 32'h7);
        check("qry_id0_rdy", 32'(qry_rdy1), 32'd0);
        cdb(5'd1, 32'h99, 1'b0);
        drain("drain_qry");
        qry_id1 = '0; qry_id2 = '0;

        // Mispredicted branch flushes; correctly predicted branch retires normally.
        do_reset();
        expect_commit(5'd0, 5'd1, 32'h55);
        alloc(5'd0, 1'b1, 1'b0, 32'h1000);
        alloc(5'd1, 1'b0, 1'b0, '0);
        alloc(5'd2, 1'b0, 1'b0, '0);
        alloc(5'd3, 1'b0, 1'b0, '0);
        cdb(5'd2, 32'hBAD, 1'b0);
        cdb(5'd1, 32'h55, 1'b1);
        check("br_commit_valid", 32'(commit_valid), 32'd1);
        check("br_no_early_rollback", 32'(rollback_signal), 32'd0);
        step();
        check("rollback_pulse", 32'(rollback_signal), 32'd1);
        check("rollback_pc", rollback_pc, 32'h1000);
        check("rollback_alloc_id", 32'(alloc_id), 32'd1);
        check("rollback_not_full", 32'(rob_full), 32'd0);
        check("rollback_no_commit", 32'(commit_valid), 32'd0);
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        cdb_valid = 1'b1; cdb_id = 5'd2; cdb_value = 32'h1234;
        step();
        idle();
        qry_id1 = 5'd2;
        #1;
        check("rollback_pulse_ends", 32'(rollback_signal), 32'd0);
        check("rollback_alloc_ignored", 32'(alloc_id), 32'd1);
        check("flushed_slot_not_ready", 32'(qry_rdy1), 32'd0);
        qry_id1 = '0;
        expect_commit(5'd0, 5'd1, 32'h66);
        alloc(5'd0, 1'b1, 1'b1, 32'h2000);
        cdb(5'd1, 32'h66, 1'b1);
        step();
        check("good_br_no_rollback", 32'(rollback_signal), 32'd0);
        check("good_br_alloc_id", 32'(alloc_id), 32'd2);
        drain("drain_br");

        // Freeze with rdy=0, resume, then reset mid-stream.
        do_reset();
        expect_commit(5'd3, 5'd1, 32'hAB);
        alloc(5'd3, 1'b0, 1'b0, '0);
        cdb(5'd1, 32'hAB, 1'b0);
        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd4;
        #1 check("freeze_commit_valid", 32'(commit_valid), 32'd0);
        step();
        step();
        check("freeze_alloc_id", 32'(alloc_id), 32'd2);
        alloc_valid = 1'b0;
        rdy = 1'b1;
        #1 check("resume_commit_valid", 32'(commit_valid), 32'd1);
        drain("drain_rdy");
        alloc(5'd4, 1'b0, 1'b0, '0);
        alloc(5'd5, 1'b0, 1'b0, '0);
        check("pre_reset_alloc_id", 32'(alloc_id), 32'd4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset_alloc_id", 32'(alloc_id), 32'd1);
        check("midreset_rob_full", 32'(rob_full), 32'd0);
        check("midreset_commit_valid", 32'(commit_valid), 32'd0);
        step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
